// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel window sequencer.
// State encoding, default pixel width and counter width helpers.
package pixel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int DW_DEF = 8;

  // Column counter width; never narrower than one bit.
  function automatic int col_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Row counter width; never narrower than one bit.
  function automatic int row_w(input int h);
    return (h > 1) ? $clog2(h) : 1;
  endfunction

endpackage

// File: rtl/pixel_window_raster_counter.sv
// Raster column/row tracker for accepted pixels.
// Reports the position of the pixel being accepted this cycle.
module raster_counter
  import pixel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  localparam int CW = col_w(IMG_W),
  localparam int RW = row_w(IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  // Current position: a clear restarts this very pixel at (0,0).
  always_comb begin
    col  = clr ? '0 : col_q;
    row  = clr ? '0 : row_q;
    last = (col == COL_MAX) && (row == ROW_MAX);
  end

  // Step to the next raster position, wrapping exactly at line/frame end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (adv) begin
      if (col == COL_MAX) begin
        col_q <= '0;
        row_q <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col_q <= col + 1'b1;
        row_q <= row;
      end
    end else if (clr) begin
      col_q <= '0;
      row_q <= '0;
    end
  end

endmodule

// File: rtl/pixel_window_ctrl.sv
// Delay-chain sequencer: feeds the tapped pixel chain and
// announces fully primed windows to the downstream detector.
module pixel_window_ctrl
  import pixel_pkg::*;
#(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int TAP_DEPTH = 7,
  parameter int DW        = DW_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DW-1:0]            s_data,
  input  logic                     s_sof,
  output logic                     shift_en,
  output logic [DW-1:0]            shift_data,
  input  logic                     m_ready,
  output logic                     win_valid,
  output logic [col_w(IMG_W)-1:0]  win_col,
  output logic [row_w(IMG_H)-1:0]  win_row,
  output logic                     border,
  output logic                     frame_done,
  output logic                     sof_err
);

  localparam int CW = col_w(IMG_W);
  localparam int RW = row_w(IMG_H);
  localparam int FW = $clog2(TAP_DEPTH + 1);

  localparam logic [FW:0]   FILL_END = (FW + 1)'(TAP_DEPTH);
  localparam logic [FW-1:0] FILL_ONE = FW'(1);

  state_t        state_q;
  state_t        state_d;
  logic [FW-1:0] fill_q;
  logic [FW-1:0] fill_d;
  logic [FW:0]   fill_inc;
  logic          acc;
  logic          start;
  logic          mid_sof;
  logic          win_set;
  logic          done_set;
  logic [CW-1:0] pos_col;
  logic [RW-1:0] pos_row;
  logic          last;

  assign shift_data = s_data;

  // Handshake, next state and window/frame events for this cycle.
  always_comb begin
    s_ready  = 1'b0;
    state_d  = state_q;
    fill_d   = fill_q;
    win_set  = 1'b0;
    done_set = 1'b0;
    fill_inc = {1'b0, fill_q} + 1'b1;

    unique case (state_q)
      IDLE:    s_ready = 1'b1;
      FILL:    s_ready = 1'b1;
      RUN:     s_ready = m_ready || !win_valid;
      default: s_ready = 1'b0;
    endcase
    s_ready = s_ready && !reset;

    acc      = s_valid && s_ready;
    start    = acc && s_sof;
    mid_sof  = start && (state_q != IDLE);
    shift_en = acc && ((state_q != IDLE) || s_sof);

    if (start) begin
      fill_d = FILL_ONE;
      if (TAP_DEPTH == 1) begin
        state_d = RUN;
        win_set = 1'b1;
      end else begin
        state_d = FILL;
      end
    end else if (acc) begin
      unique case (state_q)
        FILL: begin
          fill_d = fill_inc[FW-1:0];
          if (fill_inc >= FILL_END) begin
            state_d = RUN;
            win_set = 1'b1;
          end
        end
        RUN:     win_set = 1'b1;
        default: win_set = 1'b0;
      endcase
    end

    if (shift_en && last && !start) begin
      state_d  = IDLE;
      done_set = 1'b1;
    end
  end

  // State and fill-level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // Window presentation: new window replaces, else held until taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_valid  <= 1'b0;
      win_col    <= '0;
      win_row    <= '0;
      border     <= 1'b0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      frame_done <= done_set;
      sof_err    <= mid_sof;
      if (win_set) begin
        win_valid <= 1'b1;
        win_col   <= pos_col;
        win_row   <= pos_row;
        border    <= int'(pos_col) < TAP_DEPTH - 1;
      end else if (mid_sof || m_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

  raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .adv   (shift_en),
    .col   (pos_col),
    .row   (pos_row),
    .last  (last)
  );

endmodule

// File: tb/tb_pixel_window_ctrl.sv
// Bench for pixel_window_ctrl on a small 8x4 raster.
// Directed steps then random traffic against a frame-index model.
module tb_pixel_window_ctrl;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int TAP = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_sof;
  logic       shift_en;
  logic [7:0] shift_data;
  logic       m_ready;
  logic       win_valid;
  logic [2:0] win_col;
  logic [1:0] win_row;
  logic       border;
  logic       frame_done;
  logic       sof_err;

  always #5 clk = ~clk;

  pixel_window_ctrl #(
    .IMG_W     (W),
    .IMG_H     (H),
    .TAP_DEPTH (TAP),
    .DW        (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_sof      (s_sof),
    .shift_en   (shift_en),
    .shift_data (shift_data),
    .m_ready    (m_ready),
    .win_valid  (win_valid),
    .win_col    (win_col),
    .win_row    (win_row),
    .border     (border),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  int checks   = 0;
  int failures = 0;

  bit in_frame;
  int k;
  bit mv;
  int mc;
  int mr;
  bit mb;
  bit mdone;
  bit merr;
  int nshift;
  int ndone;
  logic [2:0] held;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    in_frame = 1'b0;
    k        = 0;
    mv       = 1'b0;
    mc       = 0;
    mr       = 0;
    mb       = 1'b0;
    mdone    = 1'b0;
    merr     = 1'b0;
  endtask

  task automatic step(input bit v, input bit sof,
                      input logic [7:0] d, input bit rdy);
    bit er;
    bit acc;
    bit set;
    int pos;
    @(negedge clk);
    s_valid = v;
    s_sof   = sof;
    s_data  = d;
    m_ready = rdy;
    #1;
    er = !in_frame || (k < TAP) || rdy || !mv;
    chk("s_ready", s_ready, er);
    chk("shift_en", shift_en, v && er && (in_frame || sof));
    chk("shift_data", shift_data, d);
    if (shift_en) nshift++;
    acc   = v && er;
    set   = 1'b0;
    pos   = 0;
    mdone = 1'b0;
    merr  = 1'b0;
    @(posedge clk);
    if (acc && sof) begin
      merr = in_frame;
      if (in_frame) mv = 1'b0;
      in_frame = 1'b1;
      k   = 1;
      pos = 0;
      set = (TAP == 1);
    end else if (acc && in_frame) begin
      pos = k;
      k++;
      set = (k >= TAP);
      if (pos == W * H - 1) begin
        mdone    = 1'b1;
        in_frame = 1'b0;
      end
    end
    if (set) begin
      mv = 1'b1;
      mc = pos % W;
      mr = pos / W;
      mb = (mc < TAP - 1);
    end else if (rdy) begin
      mv = 1'b0;
    end
    #1;
    chk("win_valid", win_valid, mv);
    if (mv) begin
      chk("win_col", win_col, mc);
      chk("win_row", win_row, mr);
      chk("border", border, mb);
    end
    chk("frame_done", frame_done, mdone);
    chk("sof_err", sof_err, merr);
    if (frame_done) ndone++;
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;
    model_reset();
    nshift = 0;
    ndone  = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Prime a window and hold it, then reset mid-stream.
    step(1'b1, 1'b1, 8'h10, 1'b0);
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
    chk("t1_pending", win_valid, 1'b1);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'hA5;
    reset   = 1'b1;
    #1;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_shift_en", shift_en, 1'b0);
    chk("rst_shift_data", shift_data, 8'hA5);
    chk("rst_async_valid", win_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_win_valid", win_valid, 1'b0);
    chk("rst_win_col", win_col, 3'd0);
    chk("rst_win_row", win_row, 2'd0);
    chk("rst_border", border, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_sof_err", sof_err, 1'b0);
    model_reset();
    @(negedge clk);
    reset   = 1'b0;
    s_valid = 1'b0;
    nshift  = 0;
    repeat (5) step(1'b1, 1'b0, 8'($urandom), 1'b1);
    chk("t1_no_shift", nshift, 0);

    // Fill: sof plus six pixels primes the first window.
    nshift = 0;
    step(1'b1, 1'b1, 8'($urandom), 1'b1);
    repeat (6) step(1'b1, 1'b0, 8'($urandom), 1'b1);
    chk("t2_shifts", nshift, 7);
    chk("t2_valid", win_valid, 1'b1);
    chk("t2_col", win_col, 3'd6);
    chk("t2_row", win_row, 2'd0);
    chk("t2_border", border, 1'b0);

    // Line wrap: border while the window straddles rows.
    step(1'b1, 1'b0, 8'($urandom), 1'b1);
    for (int c = 0; c < 7; c++) begin
      step(1'b1, 1'b0, 8'($urandom), 1'b1);
      chk("t3_row", win_row, 2'd1);
      chk("t3_border", border, c < 6);
    end

    // Backpressure: window frozen, no shifts, then resume.
    held   = win_col;
    nshift = 0;
    repeat (5) begin
      step(1'b1, 1'b0, 8'($urandom), 1'b0);
      chk("t4_hold_col", win_col, held);
      chk("t4_hold_valid", win_valid, 1'b1);
    end
    chk("t4_no_shift", nshift, 0);
    repeat (3) step(1'b1, 1'b0, 8'($urandom), 1'b1);
    chk("t4_resume", nshift, 3);

    // Full frame from a fresh sof, then a discarded pixel.
    nshift = 0;
    ndone  = 0;
    step(1'b1, 1'b1, 8'($urandom), 1'b1);
    for (int i = 1; i < 32; i++) step(1'b1, 1'b0, 8'($urandom), 1'b1);
    chk("t5_done", frame_done, 1'b1);
    chk("t5_last_col", win_col, 3'd7);
    chk("t5_last_row", win_row, 2'd3);
    step(1'b1, 1'b0, 8'($urandom), 1'b1);
    chk("t5_done_once", ndone, 1);
    chk("t5_shifts", nshift, 32);
    chk("t5_drained", win_valid, 1'b0);

    // Mid-frame sof restarts the window fill.
    step(1'b1, 1'b1, 8'($urandom), 1'b1);
    repeat (11) step(1'b1, 1'b0, 8'($urandom), 1'b1);
    step(1'b1, 1'b1, 8'($urandom), 1'b1);
    chk("t6_sof_err", sof_err, 1'b1);
    chk("t6_cleared", win_valid, 1'b0);
    repeat (5) step(1'b1, 1'b0, 8'($urandom), 1'b1);
    chk("t6_still_filling", win_valid, 1'b0);
    step(1'b1, 1'b0, 8'($urandom), 1'b1);
    chk("t6_valid", win_valid, 1'b1);
    chk("t6_col", win_col, 3'd6);
    chk("t6_row", win_row, 2'd0);

    // Random traffic with sporadic sof and backpressure.
    repeat (600) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
           8'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
